// File: rtl/sram_pkg.sv
// Shared types and helpers for the masked 1R1W SRAM model and its clear sequencer.
package sram_pkg;

  typedef enum logic {INIT, RUN} sram_state_e;

  // Widest entry the merge helper handles; callers zero-extend into it and truncate back.
  localparam int unsigned SRAM_MAX_W = 256;

  function automatic int unsigned mask_seg(input int unsigned width, input int unsigned gran);
    return width / gran;
  endfunction

  function automatic logic [SRAM_MAX_W-1:0] merge_masked(
    input logic [SRAM_MAX_W-1:0] old_v,
    input logic [SRAM_MAX_W-1:0] new_v,
    input logic [SRAM_MAX_W-1:0] mask,
    input int unsigned           gran
  );
    logic [SRAM_MAX_W-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < SRAM_MAX_W; i++) begin
      if (mask[i / gran]) res[i] = new_v[i];
    end
    return res;
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned width,
                                   input int unsigned gran);
    return (depth >= 2) && (gran > 0) && (width % gran == 0) && (width <= SRAM_MAX_W);
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then parks in RUN until the next reset.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned INIT_ON_RST = 1,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  sram_state_e   state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= (INIT_ON_RST != 0) ? INIT : RUN;
      cnt_q   <= '0;
      busy_q  <= (INIT_ON_RST != 0);
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/sram_1r1w_masked.sv
// Parametrised 1R1W synchronous SRAM with segment write mask, held read register,
// optional same-address write-to-read bypass and hardware clear after reset.
module sram_1r1w_masked
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WIDTH       = 13,
  parameter int unsigned MASK_GRAN   = 13,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned INIT_ON_RST = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned MASK_SEG   = WIDTH / MASK_GRAN
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [AW-1:0]       R0_addr,
  input  logic                R0_en,
  output logic [WIDTH-1:0]    R0_data,
  input  logic [AW-1:0]       W0_addr,
  input  logic                W0_en,
  input  logic [WIDTH-1:0]    W0_data,
  input  logic [MASK_SEG-1:0] W0_mask,
  output logic                init_busy
);

  if (!params_ok(DEPTH, WIDTH, MASK_GRAN)) begin : g_bad_params
    $error("sram_1r1w_masked: need DEPTH>=2 and WIDTH a multiple of MASK_GRAN");
  end

  logic          busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;

  sram_clear_seq #(
    .DEPTH       (DEPTH),
    .INIT_ON_RST (INIT_ON_RST)
  ) u_clear_seq (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] merged_w;
  logic [WIDTH-1:0] r_data_d, R0_data_q;
  logic             w_in_range, r_in_range;

  assign w_in_range = 32'(W0_addr) < DEPTH;
  assign r_in_range = 32'(R0_addr) < DEPTH;
  assign merged_w   = WIDTH'(merge_masked(SRAM_MAX_W'(mem[W0_addr]), SRAM_MAX_W'(W0_data),
                                          SRAM_MAX_W'(W0_mask), MASK_GRAN));

  // NOTE: the array has no reset branch; only the clear sequence initialises contents.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (W0_en && w_in_range && (|W0_mask)) begin
      mem[W0_addr] <= merged_w;
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    r_data_d = R0_data_q;
    if (busy) begin
      r_data_d = '0;
    end else if (R0_en) begin
      if (!r_in_range) begin
        r_data_d = '0;
      end else if ((BYPASS != 0) && W0_en && w_in_range && (W0_addr == R0_addr)) begin
        r_data_d = merged_w;
      end else begin
        r_data_d = mem[R0_addr];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) R0_data_q <= '0;
    else          R0_data_q <= r_data_d;
  end

  assign R0_data   = R0_data_q;
  assign init_busy = busy;

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Randomised bench for sram_1r1w_masked: three configurations against an array-level reference model.
module tb_sram_1r1w_masked;

  typedef struct packed {
    logic        ren;
    logic [8:0]  raddr;
    logic        wen;
    logic [8:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  wmask;
  } op_t;

  logic clock, reset_n;

  logic a_ren, a_wen, a_busy;
  logic [8:0] a_raddr, a_waddr;
  logic [15:0] a_wdata, a_rdata;
  logic [3:0] a_wmask;

  logic b_ren, b_wen, b_busy;
  logic [8:0] b_raddr, b_waddr;
  logic [15:0] b_wdata, b_rdata;
  logic [1:0] b_wmask;

  logic c_ren, c_wen, c_busy, c_wmask;
  logic [1:0] c_raddr, c_waddr;
  logic [7:0] c_wdata, c_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model_a [512];
  logic [15:0] model_b [512];
  logic [15:0] hold_a, hold_b;

  sram_1r1w_masked #(.DEPTH(512), .WIDTH(16), .MASK_GRAN(4), .BYPASS(1),
                     .INIT_ON_RST(1), .INIT_VALUE(16'h01A5)) u_a (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(a_raddr), .R0_en(a_ren), .R0_data(a_rdata),
    .W0_addr(a_waddr), .W0_en(a_wen), .W0_data(a_wdata), .W0_mask(a_wmask),
    .init_busy(a_busy));

  sram_1r1w_masked #(.DEPTH(300), .WIDTH(16), .MASK_GRAN(8), .BYPASS(0),
                     .INIT_ON_RST(1), .INIT_VALUE(16'h0000)) u_b (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(b_raddr), .R0_en(b_ren), .R0_data(b_rdata),
    .W0_addr(b_waddr), .W0_en(b_wen), .W0_data(b_wdata), .W0_mask(b_wmask),
    .init_busy(b_busy));

  sram_1r1w_masked #(.DEPTH(4), .WIDTH(8), .MASK_GRAN(8), .BYPASS(1),
                     .INIT_ON_RST(0), .INIT_VALUE(8'h00)) u_c (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(c_raddr), .R0_en(c_ren), .R0_data(c_rdata),
    .W0_addr(c_waddr), .W0_en(c_wen), .W0_data(c_wdata), .W0_mask(c_wmask),
    .init_busy(c_busy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic ren, input int raddr, input logic wen,
                             input int waddr, input int wdata, input int wmask);
    op_t o;
    o.ren = ren; o.raddr = 9'(raddr); o.wen = wen; o.waddr = 9'(waddr);
    o.wdata = 16'(wdata); o.wmask = 4'(wmask);
    return o;
  endfunction

  // Segment merge straight from the rule: masked segments take new data, others keep old.
  function automatic logic [15:0] seg_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                            input logic [3:0] m, input int gran);
    logic [15:0] r, sm;
    r = old_v;
    for (int s = 0; s < 16 / gran; s++) begin
      if (m[s]) begin
        sm = 16'(((1 << gran) - 1) << (s * gran));
        r  = (r & ~sm) | (new_v & sm);
      end
    end
    return r;
  endfunction

  function automatic op_t rand_op(input bit for_b);
    op_t o;
    o.ren   = 1'($urandom_range(0, 1));
    o.wen   = 1'($urandom_range(0, 1));
    o.wdata = 16'($urandom);
    o.wmask = 4'($urandom);
    if (for_b) begin
      o.raddr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(290, 511)) : 9'($urandom_range(0, 15));
      o.waddr = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(290, 511)) : 9'($urandom_range(0, 15));
    end else begin
      o.raddr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      o.waddr = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
    end
    return o;
  endfunction

  task automatic drive_a(input op_t o);
    a_ren = o.ren; a_raddr = o.raddr; a_wen = o.wen;
    a_waddr = o.waddr; a_wdata = o.wdata; a_wmask = o.wmask;
  endtask

  task automatic drive_b(input op_t o);
    b_ren = o.ren; b_raddr = o.raddr; b_wen = o.wen;
    b_waddr = o.waddr; b_wdata = o.wdata; b_wmask = o.wmask[1:0];
  endtask

  // One RUN-mode cycle on A and B: predict from the model, clock, compare.
  task automatic step(input op_t oa, input op_t ob);
    logic [15:0] ea, eb;
    drive_a(oa);
    drive_b(ob);
    ea = hold_a;
    if (oa.ren) begin
      ea = model_a[oa.raddr];
      if (oa.wen && oa.waddr == oa.raddr) ea = seg_merge(ea, oa.wdata, oa.wmask, 4);
    end
    eb = hold_b;
    if (ob.ren) eb = (ob.raddr >= 9'd300) ? 16'h0000 : model_b[ob.raddr];
    if (oa.wen) model_a[oa.waddr] = seg_merge(model_a[oa.waddr], oa.wdata, oa.wmask, 4);
    if (ob.wen && ob.waddr < 9'd300)
      model_b[ob.waddr] = seg_merge(model_b[ob.waddr], ob.wdata, {2'b00, ob.wmask[1:0]}, 8);
    @(posedge clock); #1;
    check("a_rdata", 32'(a_rdata), 32'(ea));
    check("b_rdata", 32'(b_rdata), 32'(eb));
    hold_a = ea;
    hold_b = eb;
  endtask

  task automatic pulse_reset();
    drive_a(mk(0, 0, 0, 0, 0, 0));
    drive_b(mk(0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    #3;
    check("rst_a_rdata", 32'(a_rdata), 32'h0);
    check("rst_b_rdata", 32'(b_rdata), 32'h0);
    check("rst_c_rdata", 32'(c_rdata), 32'h0);
    check("rst_a_busy", 32'(a_busy), 32'h1);
    check("rst_b_busy", 32'(b_busy), 32'h1);
    check("rst_c_busy", 32'(c_busy), 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    hold_a = '0;
    hold_b = '0;
  endtask

  // Runs clear cycles with junk traffic while busy; returns the cycle on which each busy dropped.
  task automatic do_clear(input int max_cyc, output int da, output int db);
    da = 0;
    db = 0;
    for (int cyc = 1; cyc <= max_cyc && (da == 0 || db == 0); cyc++) begin
      drive_a(a_busy ? rand_op(1'b0) : mk(0, 0, 0, 0, 0, 0));
      drive_b(b_busy ? rand_op(1'b1) : mk(0, 0, 0, 0, 0, 0));
      @(posedge clock); #1;
      check("init_a_rdata", 32'(a_rdata), 32'h0);
      check("init_b_rdata", 32'(b_rdata), 32'h0);
      if (da == 0 && !a_busy) da = cyc;
      if (db == 0 && !b_busy) db = cyc;
    end
    drive_a(mk(0, 0, 0, 0, 0, 0));
    drive_b(mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic fill_models();
    for (int i = 0; i < 512; i++) begin
      model_a[i] = 16'h01A5;
      model_b[i] = 16'h0000;
    end
  endtask

  initial begin
    int da, db;
    op_t idle;
    idle = mk(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    c_ren = 0; c_wen = 0; c_raddr = 0; c_waddr = 0; c_wdata = 0; c_wmask = 0;
    drive_a(idle);
    drive_b(idle);
    hold_a = '0;
    hold_b = '0;
    #2;

    // First clear after reset, then corner reads.
    pulse_reset();
    do_clear(700, da, db);
    check("clear_len_512", 32'(da), 32'd512);
    check("clear_len_300", 32'(db), 32'd300);
    fill_models();
    step(mk(1, 0, 0, 0, 0, 0), idle);
    check("rd0_init", 32'(a_rdata), 32'h1A5);
    step(mk(1, 255, 0, 0, 0, 0), idle);
    check("rd255_init", 32'(a_rdata), 32'h1A5);
    step(mk(1, 511, 0, 0, 0, 0), idle);
    check("rd511_init", 32'(a_rdata), 32'h1A5);

    // Dirty some entries, then reset mid-clear and demand a full restart.
    step(mk(0, 0, 1, 5, 16'h1111, 4'hF), mk(0, 0, 1, 5, 16'h2222, 4'h3));
    pulse_reset();
    do_clear(100, da, db);
    pulse_reset();
    do_clear(700, da, db);
    check("restart_len_512", 32'(da), 32'd512);
    check("restart_len_300", 32'(db), 32'd300);
    fill_models();
    for (int i = 0; i < 512; i++) step(mk(1, i, 0, 0, 0, 0), mk(1, i, 0, 0, 0, 0));

    // Segment mask merge.
    step(mk(0, 0, 1, 7, 16'hFFFF, 4'hF), idle);
    step(mk(0, 0, 1, 7, 16'h1234, 4'b0101), idle);
    step(mk(1, 7, 0, 0, 0, 0), idle);
    check("mask_merge", 32'(a_rdata), 32'hF2F4);

    // Same-address write/read: bypass on A, old data on B.
    step(mk(0, 0, 1, 3, 0, 4'hF), mk(0, 0, 1, 3, 0, 4'h3));
    step(mk(1, 3, 1, 3, 16'hABCD, 4'hF), mk(1, 3, 1, 3, 16'hABCD, 4'h3));
    check("bypass_new", 32'(a_rdata), 32'hABCD);
    check("nobypass_old", 32'(b_rdata), 32'h0000);
    step(idle, mk(1, 3, 0, 0, 0, 0));
    check("nobypass_next", 32'(b_rdata), 32'hABCD);

    // Read data holds while R0_en is low.
    step(mk(0, 0, 1, 9, 16'h0055, 4'hF), idle);
    step(mk(1, 9, 0, 0, 0, 0), idle);
    check("hold_first", 32'(a_rdata), 32'h55);
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 9, 1, 9, 16'h0066, 4'hF), idle);
      check("hold_keep", 32'(a_rdata), 32'h55);
    end
    step(mk(1, 9, 0, 0, 0, 0), idle);
    check("hold_release", 32'(a_rdata), 32'h66);

    // Out-of-range access on the non-power-of-two array.
    step(idle, mk(0, 0, 1, 310, 16'hBEEF, 4'h3));
    step(idle, mk(1, 310, 0, 0, 0, 0));
    check("oor_read", 32'(b_rdata), 32'h0);
    step(idle, mk(1, 54, 0, 0, 0, 0));
    check("oor_no_alias", 32'(b_rdata), 32'h0);

    for (int i = 0; i < 1500; i++) step(rand_op(1'b0), rand_op(1'b1));

    // No-clear configuration: never busy, plain write/read and full-mask bypass.
    c_wen = 1; c_waddr = 2'd2; c_wdata = 8'h5A; c_wmask = 1'b1;
    @(posedge clock); #1;
    c_wen = 0; c_ren = 1; c_raddr = 2'd2;
    @(posedge clock); #1;
    check("c_rd", 32'(c_rdata), 32'h5A);
    c_wen = 1; c_waddr = 2'd1; c_wdata = 8'h3C; c_raddr = 2'd1;
    @(posedge clock); #1;
    check("c_bypass", 32'(c_rdata), 32'h3C);
    check("c_busy", 32'(c_busy), 32'h0);
    c_wen = 0; c_ren = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
